// File: rtl/pe_serial_feeder.sv
// Upstream sequencer for a binary-serial border PE: loads a weight, then streams ifm operands,
// holding each for IWIDTH cycles while idx sweeps the bit positions.
module pe_serial_feeder #(
  parameter int unsigned IWIDTH = 8,
  parameter int unsigned IDEPTH = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     w_valid,
  input  logic signed [IWIDTH-1:0] w_data,
  output logic                     w_ready,
  input  logic                     i_valid,
  input  logic signed [IWIDTH-1:0] i_data,
  input  logic                     i_last,
  output logic                     i_ready,
  output logic signed [IWIDTH-1:0] ifm,
  output logic signed [IWIDTH-1:0] wght,
  output logic [IDEPTH-1:0]        idx,
  output logic                     en_i,
  output logic                     clr_i,
  output logic                     en_w,
  output logic                     clr_w,
  output logic                     en_o,
  output logic                     clr_o,
  output logic                     done
);

  if (IWIDTH != 2 ** IDEPTH) begin : g_param_check
    $error("pe_serial_feeder: IWIDTH must equal 2**IDEPTH");
  end

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StWaitI  = 2'd1;
  localparam logic [1:0] StSerial = 2'd2;

  localparam logic [IDEPTH-1:0] IdxLast = IDEPTH'(IWIDTH - 1);
  localparam logic [IDEPTH-1:0] IdxPen  = IDEPTH'(IWIDTH - 2);

  logic [1:0]               state_q, state_d;
  logic signed [IWIDTH-1:0] ifm_q, ifm_d;
  logic signed [IWIDTH-1:0] wght_q, wght_d;
  logic [IDEPTH-1:0]        idx_q, idx_d;
  logic                     en_i_q, en_i_d, clr_i_q, clr_i_d;
  logic                     en_w_q, en_w_d, clr_w_q, clr_w_d;
  logic                     en_o_q, en_o_d, clr_o_q, clr_o_d;
  logic                     done_q, done_d;
  logic                     last_q, last_d;
  logic                     start_q, start_d;
  logic                     w_fire, i_fire;

  // Readys are decoded from state; flush blocks any handshake in its cycle.
  assign w_ready = (state_q == StIdle) && !flush;
  assign i_ready = !flush && ((state_q == StWaitI) ||
                              ((state_q == StSerial) && (idx_q == IdxLast) && !last_q));
  assign w_fire  = w_valid && w_ready;
  assign i_fire  = i_valid && i_ready;

  always_comb begin
    state_d = state_q;
    ifm_d   = ifm_q;
    wght_d  = wght_q;
    idx_d   = idx_q;
    last_d  = last_q;
    start_d = start_q;
    en_i_d  = 1'b0;
    clr_i_d = 1'b0;
    en_w_d  = 1'b0;
    clr_w_d = 1'b0;
    en_o_d  = 1'b0;
    clr_o_d = 1'b0;
    done_d  = 1'b0;
    if (flush) begin
      state_d = StIdle;
      idx_d   = '0;
      start_d = 1'b0;
      clr_i_d = 1'b1;
      clr_w_d = 1'b1;
      clr_o_d = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (w_fire) begin
            wght_d  = w_data;
            en_w_d  = 1'b1;
            start_d = 1'b1;
            state_d = StWaitI;
          end
        end
        StSerial: begin
          if (idx_q != IdxLast) begin
            idx_d  = idx_q + 1'b1;
            en_o_d = (idx_q == IdxPen);
          end else if (!i_fire) begin
            if (last_q) begin
              done_d  = 1'b1;
              state_d = StIdle;
            end else begin
              state_d = StWaitI;
            end
          end
        end
        StWaitI: ;
        default: state_d = StIdle;
      endcase
      // Operand load, either from WAIT_I or back-to-back on the final bit.
      if (i_fire) begin
        ifm_d   = i_data;
        en_i_d  = 1'b1;
        idx_d   = '0;
        clr_o_d = start_q;
        start_d = 1'b0;
        last_d  = i_last;
        state_d = StSerial;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ifm_q   <= '0;
      wght_q  <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      start_q <= 1'b0;
      en_i_q  <= 1'b0;
      clr_i_q <= 1'b0;
      en_w_q  <= 1'b0;
      clr_w_q <= 1'b0;
      en_o_q  <= 1'b0;
      clr_o_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ifm_q   <= ifm_d;
      wght_q  <= wght_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      start_q <= start_d;
      en_i_q  <= en_i_d;
      clr_i_q <= clr_i_d;
      en_w_q  <= en_w_d;
      clr_w_q <= clr_w_d;
      en_o_q  <= en_o_d;
      clr_o_q <= clr_o_d;
      done_q  <= done_d;
    end
  end

  assign ifm   = ifm_q;
  assign wght  = wght_q;
  assign idx   = idx_q;
  assign en_i  = en_i_q;
  assign clr_i = clr_i_q;
  assign en_w  = en_w_q;
  assign clr_w = clr_w_q;
  assign en_o  = en_o_q;
  assign clr_o = clr_o_q;
  assign done  = done_q;

endmodule

// File: tb/tb_pe_serial_feeder.sv
// Bench for pe_serial_feeder: scheduled vectors checked per cycle against a timeline model
// derived from operand accept times.
module tb_pe_serial_feeder;

  localparam int IW = 8;

  typedef logic [27:0] obs_t;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          w_valid, w_ready, i_valid, i_last, i_ready;
  logic [IW-1:0] w_data, i_data, ifm, wght;
  logic [2:0]    idx;
  logic          en_i, clr_i, en_w, clr_w, en_o, clr_o, done;
  obs_t          obs;

  int n_checks;
  int n_fail;

  // Current vector plan and state carried across vectors.
  logic [IW-1:0] cur_w;
  logic [IW-1:0] ops[8];
  int            gap[8];
  int            acc[8];
  int            n_ops;
  int            end_c;
  logic [IW-1:0] prev_ifm, prev_w;
  logic [2:0]    prev_idx;

  always #5 clk = ~clk;

  pe_serial_feeder #(.IWIDTH(IW), .IDEPTH(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .w_valid (w_valid),
    .w_data  (w_data),
    .w_ready (w_ready),
    .i_valid (i_valid),
    .i_data  (i_data),
    .i_last  (i_last),
    .i_ready (i_ready),
    .ifm     (ifm),
    .wght    (wght),
    .idx     (idx),
    .en_i    (en_i),
    .clr_i   (clr_i),
    .en_w    (en_w),
    .clr_w   (clr_w),
    .en_o    (en_o),
    .clr_o   (clr_o),
    .done    (done)
  );

  assign obs = {ifm, wght, idx, en_i, clr_i, en_w, clr_w, en_o, clr_o, done, w_ready, i_ready};

  function automatic obs_t pack(input logic [IW-1:0] f, input logic [IW-1:0] w,
                                input logic [2:0] x, input logic eni, input logic clri,
                                input logic enw, input logic clrw, input logic eno,
                                input logic clro, input logic dn, input logic wr,
                                input logic ir);
    return {f, w, x, eni, clri, enw, clrw, eno, clro, dn, wr, ir};
  endfunction

  // Accept cycle of each operand: weight accepted at end of cycle 0, operand j offered
  // gap[j] cycles after it could first be taken.
  function automatic void plan_vector(input int n);
    n_ops  = n;
    acc[0] = 2 + gap[0];
    for (int j = 1; j < n; j++) acc[j] = acc[j-1] + IW + gap[j];
    end_c = acc[n-1] + IW;
  endfunction

  function automatic void finish_vector();
    prev_ifm = ops[n_ops-1];
    prev_idx = 3'(IW - 1);
    prev_w   = cur_w;
  endfunction

  function automatic obs_t model_at(input int c);
    logic [IW-1:0] e_ifm = prev_ifm;
    logic [IW-1:0] e_w   = prev_w;
    logic [2:0]    e_idx = prev_idx;
    logic e_eni = 1'b0, e_enw = 1'b0, e_eno = 1'b0, e_clro = 1'b0, e_done = 1'b0;
    logic e_wr = 1'b0, e_ir = 1'b0;
    int k;
    if (c == 0) begin
      e_wr = 1'b1;
    end else begin
      e_w   = cur_w;
      e_enw = (c == 1);
      e_ir  = 1'b1;
      for (int j = 0; j < n_ops; j++) begin
        if (c >= acc[j]) begin
          k      = c - acc[j];
          e_ifm  = ops[j];
          e_idx  = (k >= IW - 1) ? 3'(IW - 1) : 3'(k);
          e_eni  = (k == 0);
          e_clro = (k == 0) && (j == 0);
          e_eno  = (k == IW - 1);
          if (k < IW - 1) e_ir = 1'b0;
          else if (k == IW - 1) e_ir = (j < n_ops - 1);
          else e_ir = 1'b1;
        end
      end
      if (c == end_c) begin
        e_done = 1'b1;
        e_wr   = 1'b1;
        e_ir   = 1'b0;
      end
    end
    return pack(e_ifm, e_w, e_idx, e_eni, 1'b0, e_enw, 1'b0, e_eno, e_clro, e_done, e_wr, e_ir);
  endfunction

  // mode 0: quiet; 1: next operand held on i_valid while not ready; 2: random junk offers.
  task automatic drive(input int c, input int mode);
    obs_t e = model_at(c);
    int pj = -1;
    int nj = -1;
    for (int j = 0; j < n_ops; j++) begin
      if (c == acc[j] - 1) pj = j;
      if (nj < 0 && acc[j] - 1 > c) nj = j;
    end
    flush   = 1'b0;
    w_valid = (c == 0);
    w_data  = (c == 0) ? cur_w : IW'($urandom);
    if (mode == 2 && c > 0 && c != end_c) w_valid = 1'($urandom);
    i_valid = 1'b0;
    i_data  = IW'($urandom);
    i_last  = 1'($urandom);
    if (pj >= 0) begin
      i_valid = 1'b1;
      i_data  = ops[pj];
      i_last  = (pj == n_ops - 1);
    end else if (!e[0]) begin
      if (mode == 2) begin
        i_valid = 1'($urandom);
      end else if (mode == 1 && c > 0 && nj >= 0) begin
        i_valid = 1'b1;
        i_data  = ops[nj];
        i_last  = (nj == n_ops - 1);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush   = 1'b0;
    w_valid = 1'b0;
    i_valid = 1'b0;
    i_last  = 1'b0;
  endtask

  task automatic test_reset();
    obs_t rv, e;
    logic [IW-1:0] wd, id;
    rv = pack('0, '0, 3'd0, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (obs !== rv) begin n_fail++; $display("FAIL reset_init got=%h exp=%h", obs, rv); end
    tick();
    rst = 1'b0;
    wd  = IW'($urandom);
    id  = IW'($urandom);
    tick(); w_valid = 1'b1; w_data = wd;
    tick(); w_valid = 1'b0; i_valid = 1'b1; i_data = id; i_last = 1'b1;
    tick(); i_valid = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    e = pack(id, wd, 3'd3, 0, 0, 0, 0, 0, 0, 0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL reset_pre_serial got=%h exp=%h", obs, e); end
    tick(); rst = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (obs !== rv) begin n_fail++; $display("FAIL reset_mid_serial got=%h exp=%h", obs, rv); end
    tick(); rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_checks++;
      if (obs !== rv) begin n_fail++; $display("FAIL reset_after i=%0d got=%h exp=%h", i, obs, rv); end
      tick();
    end
    prev_ifm = '0; prev_w = '0; prev_idx = '0;
  endtask

  task automatic test_single();
    obs_t e;
    cur_w = 8'd3; ops[0] = 8'hFB; gap[0] = 1;
    plan_vector(1);
    for (int c = 0; c <= end_c; c++) begin
      tick(); drive(c, 0);
      @(negedge clk);
      e = model_at(c);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL single c=%0d got=%h exp=%h", c, obs, e); end
    end
    finish_vector();
  endtask

  task automatic test_back_to_back();
    obs_t e;
    int n_eno = 0, n_ir = 0;
    cur_w = IW'($urandom);
    for (int j = 0; j < 4; j++) begin ops[j] = IW'(j + 1); gap[j] = 0; end
    plan_vector(4);
    for (int c = 0; c <= end_c; c++) begin
      tick(); drive(c, 1);
      @(negedge clk);
      e = model_at(c);
      if (en_o === 1'b1) n_eno++;
      if (c > 1 && i_ready === 1'b1) n_ir++;
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL b2b c=%0d got=%h exp=%h", c, obs, e); end
    end
    finish_vector();
    n_checks++;
    if (n_eno != 4) begin n_fail++; $display("FAIL b2b_en_o_count got=%0d exp=4", n_eno); end
    n_checks++;
    if (n_ir != 3) begin n_fail++; $display("FAIL b2b_i_ready_count got=%0d exp=3", n_ir); end
  endtask

  task automatic test_stall();
    obs_t e;
    cur_w = IW'($urandom);
    for (int j = 0; j < 3; j++) begin ops[j] = IW'($urandom); gap[j] = (j == 0) ? 1 : 5; end
    plan_vector(3);
    for (int c = 0; c <= end_c; c++) begin
      tick(); drive(c, 0);
      @(negedge clk);
      e = model_at(c);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL stall c=%0d got=%h exp=%h", c, obs, e); end
    end
    finish_vector();
  endtask

  task automatic test_flush();
    obs_t e;
    int fc;
    cur_w = IW'($urandom);
    for (int j = 0; j < 2; j++) begin ops[j] = IW'($urandom); gap[j] = 0; end
    plan_vector(2);
    fc = acc[0] + 4;
    for (int c = 0; c <= fc; c++) begin
      tick(); drive(c, 0);
      if (c == fc) begin flush = 1'b1; w_valid = 1'b1; i_valid = 1'b1; end
      @(negedge clk);
      e = model_at(c);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL flush_run c=%0d got=%h exp=%h", c, obs, e); end
    end
    // Second flush lands in IDLE with a weight offered: must not be taken.
    tick(); flush = 1'b1; w_valid = 1'b1; w_data = IW'($urandom); i_valid = 1'b1;
    @(negedge clk);
    e = pack(ops[0], cur_w, 3'd0, 0, 1, 0, 1, 0, 1, 0, 1'b0, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL flush_pulse got=%h exp=%h", obs, e); end
    tick(); idle_inputs();
    @(negedge clk);
    e = pack(ops[0], cur_w, 3'd0, 0, 1, 0, 1, 0, 1, 0, 1'b1, 1'b0);
    n_checks++;
    if (obs !== e) begin n_fail++; $display("FAIL flush_idle got=%h exp=%h", obs, e); end
    prev_ifm = ops[0]; prev_w = cur_w; prev_idx = 3'd0;
    cur_w = IW'($urandom);
    for (int j = 0; j < 2; j++) begin ops[j] = IW'($urandom); gap[j] = j; end
    plan_vector(2);
    for (int c = 0; c <= end_c; c++) begin
      tick(); drive(c, 0);
      @(negedge clk);
      e = model_at(c);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL flush_after c=%0d got=%h exp=%h", c, obs, e); end
    end
    finish_vector();
  endtask

  task automatic test_handshake();
    obs_t e;
    e = pack(prev_ifm, prev_w, prev_idx, 0, 0, 0, 0, 0, 0, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(); w_valid = 1'b0; i_valid = 1'b1; i_data = IW'($urandom); i_last = 1'($urandom);
      @(negedge clk);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL hs_idle i=%0d got=%h exp=%h", i, obs, e); end
    end
    cur_w = IW'($urandom);
    for (int j = 0; j < 3; j++) begin ops[j] = IW'($urandom); gap[j] = j; end
    plan_vector(3);
    for (int c = 0; c <= end_c; c++) begin
      tick(); drive(c, 2);
      @(negedge clk);
      e = model_at(c);
      n_checks++;
      if (obs !== e) begin n_fail++; $display("FAIL hs_junk c=%0d got=%h exp=%h", c, obs, e); end
    end
    finish_vector();
  endtask

  task automatic test_random();
    obs_t e;
    int n, mode;
    for (int v = 0; v < 6; v++) begin
      cur_w = IW'($urandom);
      n     = int'($urandom_range(1, 4));
      mode  = int'($urandom_range(0, 2));
      for (int j = 0; j < n; j++) begin ops[j] = IW'($urandom); gap[j] = int'($urandom_range(0, 3)); end
      plan_vector(n);
      for (int c = 0; c <= end_c; c++) begin
        tick(); drive(c, mode);
        @(negedge clk);
        e = model_at(c);
        n_checks++;
        if (obs !== e) begin
          n_fail++;
          $display("FAIL random v=%0d c=%0d got=%h exp=%h", v, c, obs, e);
        end
      end
      finish_vector();
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; w_valid = 1'b0; w_data = '0;
    i_valid = 1'b0; i_data = '0; i_last = 1'b0;
    n_checks = 0; n_fail = 0; n_ops = 0; end_c = 0;
    prev_ifm = '0; prev_w = '0; prev_idx = '0; cur_w = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_handshake();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
